// File: rtl/sd4_mac_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd4_mac_scheduler -- job sequencer feeding the SD4 MAC pipeline       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sd4_mac_scheduler #(
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [4:0]        cmd_exp_bias,
  input  logic              cmd_abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [71:0]       mem_image,
  input  logic [35:0]       mem_weight,
  output logic [71:0]       mac_image,
  output logic [35:0]       mac_weight,
  output logic [4:0]        mac_exp_bias,
  output logic              mac_in_valid,
  output logic              res_valid,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] done_count,
  output logic              done_aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Output stage of the result shift register; everything below it is "still in flight".
  localparam logic [PIPE_LAT-1:0] OUT_STAGE = PIPE_LAT'(1) << (PIPE_LAT - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   issued;
  logic                abort_flag;
  logic                mac_last;
  logic [PIPE_LAT-1:0] valid_sr;
  logic [PIPE_LAT-1:0] last_sr;

  logic                accept;
  logic                rd_last;
  logic                abort_now;
  logic                pending;

  assign pending = |(valid_sr & ~OUT_STAGE);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    accept    = 1'b0;
    rd_last   = 1'b0;
    abort_now = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = (cmd_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        mem_addr = base_q + issued;
        if (cmd_abort) begin
          abort_now = 1'b1;
          state_nxt = DRAIN;
        end else begin
          mem_rd_en = 1'b1;
          if ((issued + 1'b1) == len_q) begin
            rd_last   = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      // Leave once the result now at the output is the last one in flight.
      DRAIN: begin
        if (!mac_in_valid && !pending) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q       <= '0;
      len_q        <= '0;
      issued       <= '0;
      abort_flag   <= 1'b0;
      mac_exp_bias <= '0;
    end else begin
      if (accept) begin
        base_q       <= cmd_base;
        len_q        <= cmd_len;
        mac_exp_bias <= cmd_exp_bias;
        issued       <= '0;
        abort_flag   <= 1'b0;
      end else begin
        if (mem_rd_en) begin
          issued <= issued + 1'b1;
        end
        if (abort_now) begin
          abort_flag <= 1'b1;
        end
      end
    end
  end

  // A zero-length job reaches DONE straight from IDLE, before issued is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_count   <= '0;
      done_aborted <= 1'b0;
    end else if (state_nxt == DONE && state != DONE) begin
      if (state == IDLE) begin
        done_count   <= '0;
        done_aborted <= 1'b0;
      end else begin
        done_count   <= issued;
        done_aborted <= abort_flag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_in_valid <= 1'b0;
      mac_last     <= 1'b0;
      valid_sr     <= '0;
      last_sr      <= '0;
    end else begin
      mac_in_valid <= mem_rd_en;
      mac_last     <= rd_last;
      valid_sr     <= (valid_sr << 1) | PIPE_LAT'(mac_in_valid);
      last_sr      <= (last_sr << 1) | PIPE_LAT'(mac_last);
    end
  end

  // The pipeline has no valid of its own, so bubbles must present zeros.
  assign mac_image  = mac_in_valid ? mem_image : '0;
  assign mac_weight = mac_in_valid ? mem_weight : '0;
  assign res_valid  = valid_sr[PIPE_LAT-1];
  assign res_last   = last_sr[PIPE_LAT-1];

endmodule
`default_nettype wire
